// File: rtl/wb_sample_fifo.sv
// ============================================================================
//  Module      : wb_sample_fifo
//  Description : Wishbone classic slave that buffers producer samples in a
//                FIFO and exposes DATA/STATUS/CTRL/THRESH registers plus a
//                level IRQ.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_sample_fifo #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DW        = 16,
    parameter int          DEPTH     = 16
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    input  logic [DW-1:0] sample_i,
    input  logic          sample_valid_i,
    output logic          irq_o
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    localparam logic [7:0] c_ofs_data   = 8'h00;
    localparam logic [7:0] c_ofs_status = 8'h04;
    localparam logic [7:0] c_ofs_ctrl   = 8'h08;
    localparam logic [7:0] c_ofs_thresh = 8'h0C;

    localparam logic [c_cw-1:0] c_full_count = c_cw'(DEPTH);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    logic            r_capture_en;
    logic            r_irq_en;
    logic            r_ovf;
    logic            r_unf;
    logic [8:0]      r_thresh;

    logic            w_match;
    logic            w_req;
    logic [7:0]      w_offset;
    logic            w_empty;
    logic            w_full;
    logic [8:0]      w_count9;
    logic [DW-1:0]   w_head;
    logic            w_data_rd;
    logic            w_pop;
    logic            w_unf_set;
    logic            w_ctrl_wr;
    logic            w_thresh_wr;
    logic            w_clear;
    logic            w_push_req;
    logic            w_push;
    logic            w_ovf_set;
    logic [31:0]     w_rd_data;
    logic            w_unused;

    assign w_unused = ^{wbs_dat_i[31:9], wbs_sel_i[3:2]};

    // Access decode: the request is masked while ack is high so every
    // access costs exactly two cycles even if the master holds stb.
    assign w_match  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_req    = wbs_cyc_i & wbs_stb_i & w_match & ~wbs_ack_o;
    assign w_offset = wbs_adr_i[7:0];

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_full_count);
    assign w_count9 = 9'(r_count);
    assign w_head   = r_mem[r_rd_ptr];

    assign w_data_rd   = w_req & ~wbs_we_i & (w_offset == c_ofs_data);
    assign w_pop       = w_data_rd & ~w_empty;
    assign w_unf_set   = w_data_rd & w_empty;
    assign w_ctrl_wr   = w_req & wbs_we_i & (w_offset == c_ofs_ctrl) & wbs_sel_i[0];
    assign w_thresh_wr = w_req & wbs_we_i & (w_offset == c_ofs_thresh);
    assign w_clear     = w_ctrl_wr & wbs_dat_i[2];

    // A full FIFO still accepts a push when the same cycle pops; a flush
    // swallows the push without flagging overflow.
    assign w_push_req = sample_valid_i & r_capture_en;
    assign w_push     = w_push_req & ~w_clear & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & ~w_clear & w_full & ~w_pop;

    always_comb begin
        w_rd_data = '0;
        if (!wbs_we_i) begin
            case (w_offset)
                c_ofs_data: begin
                    if (!w_empty) begin
                        w_rd_data[DW-1:0] = w_head;
                        w_rd_data[31]     = 1'b1;
                    end
                end
                c_ofs_status: w_rd_data = {12'd0, r_unf, r_ovf, w_full, w_empty, 7'd0, w_count9};
                c_ofs_ctrl:   w_rd_data = {30'd0, r_irq_en, r_capture_en};
                c_ofs_thresh: w_rd_data = {23'd0, r_thresh};
                default:      w_rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= '0;
            irq_o        <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_capture_en <= 1'b0;
            r_irq_en     <= 1'b0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
            r_thresh     <= '0;
        end else begin
            wbs_ack_o <= w_req;
            if (w_req) begin
                wbs_dat_o <= w_rd_data;
            end

            if (w_clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_aw'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_aw'(1);
                end
                r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
            end

            if (w_clear) begin
                r_ovf <= 1'b0;
            end else if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end

            if (w_clear) begin
                r_unf <= 1'b0;
            end else if (w_unf_set) begin
                r_unf <= 1'b1;
            end

            if (w_ctrl_wr) begin
                r_capture_en <= wbs_dat_i[0];
                r_irq_en     <= wbs_dat_i[1];
            end

            if (w_thresh_wr) begin
                if (wbs_sel_i[0]) begin
                    r_thresh[7:0] <= wbs_dat_i[7:0];
                end
                if (wbs_sel_i[1]) begin
                    r_thresh[8] <= wbs_dat_i[8];
                end
            end

            // A threshold above DEPTH can never be reached, so only OVF fires then.
            irq_o <= r_irq_en & (((r_thresh != 9'd0) & (w_count9 >= r_thresh)) | r_ovf);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && w_push) begin
            r_mem[r_wr_ptr] <= sample_i;
        end
    end

endmodule

`default_nettype wire

// File: doc/wb_sample_fifo.md
Name: wb_sample_fifo

Overview:
- Wishbone classic slave inside the SoC top that buffers samples from an on-chip producer, such as the sonar front-end, in a FIFO.
- Consumes the management-SoC Wishbone bus routed through the user wrapper and drives one user IRQ line.
- Firmware drains samples by reading a DATA register. Status, control and threshold registers sit alongside it in a 256-byte address window.

Parameters:
- BASE_ADDR, 32'h3000_0000, window base; decode compares wbs_adr_i[31:8] with BASE_ADDR[31:8].
- DW, 16, sample width, 1..30.
- DEPTH, 16, FIFO entries, power of two, 2..256.

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte lane selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge, registered.
- wbs_dat_o  out  32  read data, registered.
- sample_i  in  DW  producer sample.
- sample_valid_i  in  1  one-cycle push strobe.
- irq_o  out  1  level interrupt, registered.

Behaviour:
- Reset values (synchronous, wb_rst_i high at a rising edge):
  - wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
  - FIFO empty, pointers=0, count=0.
  - CTRL=0, THRESH=0, OVF=0, UNF=0.
  - Reset mid-transaction drops the access with no ack. Stored samples are lost.
- Request:
  - req = wbs_cyc_i & wbs_stb_i & match & ~wbs_ack_o.
  - Accesses outside the window are ignored (no ack, dat_o unchanged).
- Handshake and latency:
  - req in cycle N gives wbs_ack_o=1 for exactly cycle N+1, with wbs_dat_o valid in N+1.
  - Ack returns to 0 in N+2 even if stb stays high.
  - Back-to-back accesses therefore take 2 cycles each.
- Side effects: all register writes and FIFO pops commit at the edge where ack rises.
- Register map (offset = wbs_adr_i[7:0]):
  - 0x00 DATA, RO:
    - Read returns {valid, zeros, head sample}: bit31=1 if non-empty, bits[DW-1:0]=head.
    - A read while non-empty pops the FIFO.
    - A read while empty returns 0 and sets UNF.
    - Writes are acked and ignored.
  - 0x04 STATUS, RO:
    - bits[8:0]=count.
    - bit16=empty, bit17=full, bit18=OVF, bit19=UNF.
  - 0x08 CTRL, RW, bits[2:0] honored only if wbs_sel_i[0]:
    - bit0 capture_en.
    - bit1 irq_en.
    - bit2 clear: write-1 pulse; flushes the FIFO and clears OVF/UNF that cycle. Reads as 0.
  - 0x0C THRESH, RW, bits[8:0]; byte0 needs sel[0], bit8 needs sel[1].
  - Other offsets: ack, read 0, writes ignored.
- Push:
  - sample_valid_i & capture_en pushes sample_i.
  - Push while full with no pop in the same cycle drops the sample and sets OVF (sticky).
  - Push while full with a simultaneous pop is accepted: count unchanged, no OVF.
- Simultaneous push and pop on a non-empty FIFO: count unchanged, read data is the old head.
- Push into an empty FIFO: the sample is readable by a request starting the next cycle.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Clear precedence: clear beats a same-cycle push (the push is dropped, not counted as overflow).
- irq_o, registered, updated one cycle after its inputs change:
  - irq_o = irq_en & ((THRESH!=0 & count>=THRESH) | OVF).
  - THRESH greater than DEPTH means level-triggered IRQ never fires.

Test Plan:
- Reset, then read STATUS at 0x3000_0004 -> ack 1 cycle later, data 0x0001_0000. irq_o=0 throughout.
- Write CTRL=0x3 and THRESH=4; push 0x0011, 0x0022, 0x0033, 0x0044 -> irq_o rises 1 cycle after count reaches 4. Four DATA reads return 0x8000_0011..0x8000_0044 in order. irq_o falls after the first read.
- Push 17 samples with DEPTH=16 -> STATUS=0x0006_0010 (full+OVF, count 16); the 17th sample is absent on drain. Write CTRL=0x5 -> STATUS=0x0001_0000.
- Read DATA while empty -> data 0x0000_0000, UNF set, count stays 0. A push with a same-cycle DATA read while full keeps count=16 and OVF=0.
- Hold stb/cyc high for 6 cycles on one address -> ack pattern 0,1,0,1,0,1. Each DATA read pops exactly one entry.
- Access 0x3000_0100 (out of window) -> no ack. Mid-read reset -> ack never asserts, and STATUS after reset = 0x0001_0000.
